// File: rtl/mem_req_master.sv
// Single-outstanding memory request initiator: takes one CPU load/store, issues a one-cycle
// strobe, drives store data on the shared bus, waits (bounded) for completion and pulses a response.
module mem_req_master #(
    parameter  int MEM_DEPTH  = 8,
    parameter  int DATA_WIDTH = 32,
    parameter  int TIMEOUT    = 15,
    localparam int ADDR_WIDTH = $clog2(MEM_DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cpu_req_valid,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic                  cpu_ready,
    output logic                  resp_valid,
    output logic                  resp_err,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  mem_req_valid,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    inout  wire  [DATA_WIDTH-1:0] mem_data,
    input  logic                  mem_data_valid
);

    localparam int TIMER_WIDTH = $clog2(TIMEOUT + 1);
    localparam logic [TIMER_WIDTH-1:0] TIMER_LAST = TIMER_WIDTH'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t                  state_reg;
    state_t                  state_next;
    logic [ADDR_WIDTH-1:0]   addr_reg;
    logic                    we_reg;
    logic [DATA_WIDTH-1:0]   wdata_reg;
    logic [TIMER_WIDTH-1:0]  timer_reg;
    logic                    err_reg;
    logic [DATA_WIDTH-1:0]   rdata_reg;
    logic                    bus_active;
    logic                    drive_en;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // WAIT exits on completion, or on the cycle the timer would reach TIMEOUT.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (cpu_req_valid) state_next = ISSUE;
            ISSUE:   state_next = WAIT;
            WAIT:    if (mem_data_valid || (timer_reg == TIMER_LAST)) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_reg  <= '0;
            we_reg    <= 1'b0;
            wdata_reg <= '0;
            timer_reg <= '0;
            err_reg   <= 1'b0;
            rdata_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (cpu_req_valid) begin
                        addr_reg  <= cpu_addr;
                        we_reg    <= cpu_we;
                        wdata_reg <= cpu_wdata;
                    end
                end
                ISSUE: begin
                    timer_reg <= '0;
                    err_reg   <= 1'b0;
                end
                WAIT: begin
                    if (mem_data_valid) begin
                        err_reg <= 1'b0;
                        if (!we_reg) begin
                            rdata_reg <= mem_data;
                        end
                    end else begin
                        timer_reg <= timer_reg + 1'b1;
                        err_reg   <= (timer_reg == TIMER_LAST);
                    end
                end
                default: ;
            endcase
        end
    end

    // Every output is a decode of flops only; cpu_* never reaches mem_* combinationally.
    always_comb begin
        bus_active    = (state_reg == ISSUE) || (state_reg == WAIT);
        drive_en      = bus_active && we_reg;
        cpu_ready     = (state_reg == IDLE);
        mem_req_valid = (state_reg == ISSUE);
        mem_we        = bus_active && we_reg;
        mem_addr      = addr_reg;
        resp_valid    = (state_reg == RESP);
        resp_err      = (state_reg == RESP) && err_reg;
        resp_rdata    = rdata_reg;
    end

    assign mem_data = drive_en ? wdata_reg : {DATA_WIDTH{1'bz}};

endmodule
